// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered bitwise logic unit with handshake, accumulator, flags and transfer count
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [WIDTH-1:0]             A,
    input  logic [WIDTH-1:0]             B,
    input  logic [2:0]                   OP,
    input  logic                         ACC,
    input  logic                         LOAD,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [WIDTH-1:0]             Y,
    output logic                         ZERO,
    output logic [$clog2(WIDTH+1)-1:0]   ONES,
    output logic                         PARITY,
    output logic [CNT_W-1:0]             TXN_CNT
);

    localparam int OW = $clog2(WIDTH+1);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [OW-1:0]    ones_c;
    logic             accept;
    logic             xfer;

    // The output slot is free when empty or being drained this same cycle.
    assign IN_READY = !OUT_VALID || OUT_READY;
    assign accept   = IN_VALID && IN_READY;
    assign xfer     = OUT_VALID && OUT_READY;

    always_comb begin
        s = ACC ? acc_q : B;
        r = '0;
        if (LOAD) begin
            r = B;
        end else begin
            case (OP)
                3'b000:  r = A & s;
                3'b001:  r = A | s;
                3'b010:  r = A ^ s;
                3'b011:  r = ~(A & s);
                3'b100:  r = ~(A | s);
                3'b101:  r = ~(A ^ s);
                3'b110:  r = ~A;
                default: r = A;
            endcase
        end
    end

    always_comb begin
        ones_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_c = ones_c + OW'(r[i]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            Y         <= '0;
            ZERO      <= 1'b1;
            ONES      <= '0;
            PARITY    <= 1'b0;
        end else if (accept) begin
            OUT_VALID <= 1'b1;
            Y         <= r;
            ZERO      <= (r == '0);
            ONES      <= ones_c;
            PARITY    <= ^r;
        end else if (xfer) begin
            OUT_VALID <= 1'b0;
        end
    end

    // LOAD seeds the accumulator; a chained op (ACC=1) folds its result back in.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q <= '0;
        end else if (accept && LOAD) begin
            acc_q <= B;
        end else if (accept && ACC) begin
            acc_q <= r;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TXN_CNT <= '0;
        end else if (xfer) begin
            TXN_CNT <= TXN_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - randomized and directed checks of logic_unit_pipe against a behavioural model
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a, b;
    logic [2:0] op;
    logic       acc, load, out_ready;

    logic       in_ready, out_valid, zero, parity;
    logic [7:0] y;
    logic [3:0] ones;
    logic [15:0] txn_cnt;

    logic       in_ready4, out_valid4, zero4, parity4;
    logic [7:0] y4;
    logic [3:0] ones4;
    logic [3:0] txn_cnt4;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .OP(op), .ACC(acc), .LOAD(load),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .Y(y),
        .ZERO(zero), .ONES(ones), .PARITY(parity), .TXN_CNT(txn_cnt)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) u_dut4 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready4),
        .A(a), .B(b), .OP(op), .ACC(acc), .LOAD(load),
        .OUT_VALID(out_valid4), .OUT_READY(out_ready), .Y(y4),
        .ZERO(zero4), .ONES(ones4), .PARITY(parity4), .TXN_CNT(txn_cnt4)
    );

    int checks = 0;
    int errors = 0;

    bit         mv;
    logic [7:0] my;
    logic [7:0] macc;
    int         mcnt;
    logic [7:0] q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] fn(input logic [2:0] f, input logic [7:0] x, input logic [7:0] s);
        case (f)
            3'd0:    return x & s;
            3'd1:    return x | s;
            3'd2:    return x ^ s;
            3'd3:    return ~(x & s);
            3'd4:    return ~(x | s);
            3'd5:    return ~(x ^ s);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    task automatic model_reset();
        mv = 1'b0; my = 8'h00; macc = 8'h00; mcnt = 0; q.delete();
    endtask

    task automatic compare_all();
        chk("out_valid", out_valid, mv);
        chk("y", y, my);
        chk("zero", zero, (my == 8'h00));
        chk("ones", ones, $countones(my));
        chk("parity", parity, ^my);
        chk("txn_cnt", txn_cnt, mcnt % 65536);
        chk("txn_cnt4", txn_cnt4, mcnt % 16);
        chk("y_w4build", y4, my);
    endtask

    // Drive one cycle of inputs just after a falling edge, predict, then check at the next falling edge.
    task automatic step(input bit iv, input logic [7:0] xa, input logic [7:0] xb, input logic [2:0] xop,
                        input bit xacc, input bit xload, input bit rdy);
        bit         exp_rdy, acpt, xf;
        logic [7:0] r;
        in_valid = iv; a = xa; b = xb; op = xop; acc = xacc; load = xload; out_ready = rdy;
        #1;
        exp_rdy = !mv || rdy;
        chk("in_ready", in_ready, exp_rdy);
        acpt = iv && exp_rdy;
        xf   = mv && rdy;
        if (xf) begin
            if (q.size() == 0) begin
                chk("scoreboard_nonempty", 0, 1);
            end else begin
                chk("scoreboard_order", y, q.pop_front());
            end
            mcnt++;
        end
        if (acpt) begin
            r = xload ? xb : fn(xop, xa, xacc ? macc : xb);
            if (xload) macc = xb;
            else if (xacc) macc = r;
            my = r;
            mv = 1'b1;
            q.push_back(r);
        end else if (xf) begin
            mv = 1'b0;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        compare_all();
    endtask

    logic [7:0] ops_exp [8];

    initial begin
        ops_exp = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'h3C, 8'hC3};
        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; op = 0; acc = 0; load = 0; out_ready = 0;
        model_reset();
        do_reset();

        // Asynchronous reset while a result is held
        step(1, 8'h00, 8'hFF, 3'd0, 0, 1, 0);
        chk("pre_reset_valid", out_valid, 1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_y", y, 8'h00);
        chk("async_rst_zero", zero, 1);
        chk("async_rst_txn", txn_cnt, 16'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        step(1, 8'h00, 8'h55, 3'd1, 1, 0, 1);
        chk("acc_cleared_y", y, 8'h00);

        // All ops
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 8'hC3, 8'hA5, 3'(i), 0, 0, 1);
            chk("op_y", y, ops_exp[i]);
            if (i == 0) chk("ones_81", ones, 2);
            if (i == 1) chk("parity_e7", parity, 0);
        end
        step(0, 8'h00, 8'h00, 3'd0, 0, 0, 1);
        chk("txn_after_ops", txn_cnt, 16'd8);

        // Backpressure
        step(1, 8'h11, 8'h00, 3'd7, 0, 0, 0);
        step(1, 8'h22, 8'h00, 3'd7, 0, 0, 0);
        chk("bp_hold_y", y, 8'h11);
        chk("bp_in_ready", in_ready, 0);
        step(1, 8'h22, 8'h00, 3'd7, 0, 0, 0);
        chk("bp_hold_y2", y, 8'h11);
        step(1, 8'h22, 8'h00, 3'd7, 0, 0, 1);
        chk("bp_y2", y, 8'h22);
        step(1, 8'h33, 8'h00, 3'd7, 0, 0, 1);
        chk("bp_y3", y, 8'h33);
        step(0, 8'h00, 8'h00, 3'd7, 0, 0, 1);
        chk("bp_drained", q.size(), 0);
        chk("bp_valid_low", out_valid, 0);
        chk("bp_y_holds", y, 8'h33);

        // Accumulate
        step(1, 8'h00, 8'hFF, 3'd0, 0, 1, 1);
        chk("acc_load_y", y, 8'hFF);
        step(1, 8'hF0, 8'h00, 3'd0, 1, 0, 1);
        chk("acc_f0_y", y, 8'hF0);
        step(1, 8'h3C, 8'h00, 3'd0, 1, 0, 1);
        chk("acc_30_y", y, 8'h30);
        chk("acc_30_zero", zero, 0);
        step(1, 8'h00, 8'h00, 3'd1, 1, 0, 1);
        chk("acc_readback", y, 8'h30);

        // Zero and parity
        step(1, 8'h5A, 8'h5A, 3'd2, 0, 0, 1);
        chk("xor_zero_y", y, 8'h00);
        chk("xor_zero_flag", zero, 1);
        chk("xor_zero_ones", ones, 0);
        chk("xor_zero_par", parity, 0);
        step(1, 8'h01, 8'h00, 3'd7, 0, 0, 1);
        chk("pass01_par", parity, 1);
        chk("pass01_ones", ones, 1);

        // Counter wrap on the CNT_W=4 build
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(i < 17, 8'($urandom), 8'($urandom), 3'($urandom), 0, 0, 1);
            if (mcnt == 15 && i == 15) chk("wrap_15", txn_cnt4, 4'hF);
            if (mcnt == 16 && i == 16) chk("wrap_16", txn_cnt4, 4'h0);
            if (mcnt == 17 && i == 17) chk("wrap_17", txn_cnt4, 4'h1);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 3'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end
        step(0, 8'h00, 8'h00, 3'd0, 0, 0, 1);
        step(0, 8'h00, 8'h00, 3'd0, 0, 0, 1);
        chk("final_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
